// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port block RAM between the fetch stage (i_*) and the
// load/store stage (d_*). At most one access is granted per cycle. The RAM
// has a one-cycle read latency, so the granted requester sees its valid one
// cycle after the grant and both read-data outputs simply mirror mem_dout.
//
// Ports
//   clk, nrst           clock (rising edge), synchronous active-low reset
//   i_req/i_addr        fetch request, held until i_gnt
//   i_gnt               fetch granted this cycle (combinational)
//   i_valid/i_rdata     fetch response, one cycle after i_gnt
//   d_req/d_we/d_addr/d_wdata  data request, held until d_gnt (d_we=0 -> read)
//   d_gnt               data granted this cycle (combinational)
//   d_valid/d_rdata     read data or write ack, one cycle after d_gnt
//   mem_en/mem_we/mem_addr/mem_din/mem_dout   RAM port
//   i_stall_cnt         saturating count of fetch-stall cycles (debug)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_valid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic [DW/8-1:0] d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_valid,
    output logic [DW-1:0]   d_rdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    input  logic [DW-1:0]   mem_dout,
    output logic [15:0]     i_stall_cnt
);

    localparam int         BW         = DW / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0]  streak_r;
    logic        i_valid_r;
    logic        d_valid_r;
    logic [15:0] stall_cnt_r;
    logic        d_win_s;
    logic        i_win_s;

    // Arbitration: data has priority until it has won STREAK_MAX times in a
    // row against a waiting fetch; reset blocks every grant.
    always_comb begin
        d_win_s = 1'b0;
        i_win_s = 1'b0;
        if (!nrst) begin
            d_win_s = 1'b0;
            i_win_s = 1'b0;
        end else if (d_req && (!i_req || (streak_r < STREAK_MAX))) begin
            d_win_s = 1'b1;
        end else if (i_req) begin
            i_win_s = 1'b1;
        end else begin
            d_win_s = 1'b0;
            i_win_s = 1'b0;
        end
    end

    assign i_gnt = i_win_s;
    assign d_gnt = d_win_s;

    // RAM drive: winner's address/data, everything idle at zero otherwise.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = {BW{1'b0}};
        mem_addr = {AW{1'b0}};
        mem_din  = {DW{1'b0}};
        if (d_win_s) begin
            mem_en   = 1'b1;
            mem_we   = d_we;
            mem_addr = d_addr;
            mem_din  = d_wdata;
        end else if (i_win_s) begin
            mem_en   = 1'b1;
            mem_addr = i_addr;
        end else begin
            mem_en   = 1'b0;
        end
    end

    // Streak of data grants won while fetch is waiting; any fetch grant or
    // idle fetch cycle restarts it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            streak_r <= 4'd0;
        end else if (i_win_s || !i_req) begin
            streak_r <= 4'd0;
        end else if (d_win_s && (streak_r < STREAK_MAX)) begin
            streak_r <= streak_r + 4'd1;
        end else begin
            streak_r <= streak_r;
        end
    end

    // Response owner flags: the grant of this cycle becomes next cycle's valid.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            i_valid_r <= 1'b0;
            d_valid_r <= 1'b0;
        end else begin
            i_valid_r <= i_win_s;
            d_valid_r <= d_win_s;
        end
    end

    // Saturating fetch-stall counter.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cnt_r <= 16'd0;
        end else if (i_req && !i_win_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign i_valid     = i_valid_r;
    assign d_valid     = d_valid_r;
    assign i_rdata     = mem_dout;
    assign d_rdata     = mem_dout;
    assign i_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. A behavioural RAM sits on the DUT's
// memory port. Each cycle the bench predicts the grants and RAM drive from
// its own arbitration model, pushes the expected response into a queue and
// pops it one cycle later to check valids/read data. A second instance with
// MAX_STREAK=15 exercises stall-counter saturation.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct {
        logic        iv;
        logic        dv;
        logic        chk;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        nrst;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_gnt;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [3:0]  d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic [15:0] i_stall_cnt;

    logic        s_nrst;
    logic        s_i_req;
    logic        s_d_req;
    logic        s_i_gnt;
    logic        s_i_valid;
    logic [31:0] s_i_rdata;
    logic        s_d_gnt;
    logic        s_d_valid;
    logic [31:0] s_d_rdata;
    logic        s_mem_en;
    logic [3:0]  s_mem_we;
    logic [7:0]  s_mem_addr;
    logic [31:0] s_mem_din;
    logic [31:0] s_mem_dout;
    logic [15:0] s_i_stall_cnt;
    logic [7:0]  s_zero_addr;
    logic [3:0]  s_zero_we;
    logic [31:0] s_zero_data;

    logic [31:0] ram     [0:255];
    logic [31:0] ref_mem [0:255];
    resp_t       sbq[$];

    int          total;
    int          bad;
    int          m_streak;
    int          m_stall;
    int          stall_before;
    logic [15:0] dlog;
    logic [31:0] last_i_rdata;
    logic [31:0] last_d_rdata;

    mem_port_arbiter #(.AW(8), .DW(32), .MAX_STREAK(4)) dut (
        .clk(clk), .nrst(nrst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .i_stall_cnt(i_stall_cnt)
    );

    mem_port_arbiter #(.AW(8), .DW(32), .MAX_STREAK(15)) u_sat (
        .clk(clk), .nrst(s_nrst),
        .i_req(s_i_req), .i_addr(s_zero_addr), .i_gnt(s_i_gnt),
        .i_valid(s_i_valid), .i_rdata(s_i_rdata),
        .d_req(s_d_req), .d_we(s_zero_we), .d_addr(s_zero_addr),
        .d_wdata(s_zero_data),
        .d_gnt(s_d_gnt), .d_valid(s_d_valid), .d_rdata(s_d_rdata),
        .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_din(s_mem_din), .mem_dout(s_mem_dout), .i_stall_cnt(s_i_stall_cnt)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: one-cycle read latency, byte writes.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_din[b*8 +: 8];
            end
            mem_dout <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the currently driven inputs.
    task automatic tick();
        logic        eg_i;
        logic        eg_d;
        logic [7:0]  ea;
        resp_t       e;
        @(negedge clk);
        if (!nrst) begin
            eg_i = 1'b0;
            eg_d = 1'b0;
        end else begin
            eg_d = d_req && (!i_req || (m_streak < 4));
            eg_i = i_req && !eg_d;
        end
        ea = eg_d ? d_addr : (eg_i ? i_addr : 8'd0);
        check("i_gnt",    32'(i_gnt),    32'(eg_i));
        check("d_gnt",    32'(d_gnt),    32'(eg_d));
        check("mem_en",   32'(mem_en),   32'(eg_i | eg_d));
        check("mem_we",   32'(mem_we),   32'(eg_d ? d_we : 4'd0));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("mem_din",  mem_din,       eg_d ? d_wdata : 32'd0);
        dlog   = {dlog[14:0], d_gnt};
        e.iv   = eg_i;
        e.dv   = eg_d;
        e.chk  = eg_i || (eg_d && (d_we == 4'd0));
        e.data = ref_mem[ea];
        sbq.push_back(e);
        if (!nrst) begin
            m_streak = 0;
            m_stall  = 0;
        end else begin
            if (eg_d) begin
                for (int b = 0; b < 4; b++) begin
                    if (d_we[b]) ref_mem[d_addr][b*8 +: 8] = d_wdata[b*8 +: 8];
                end
            end
            if (eg_i || !i_req) m_streak = 0;
            else if (eg_d && (m_streak < 4)) m_streak++;
            if (i_req && !eg_i && (m_stall < 65535)) m_stall++;
        end
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("i_valid", 32'(i_valid), 32'(e.iv));
        check("d_valid", 32'(d_valid), 32'(e.dv));
        if (e.chk && e.iv) check("i_rdata", i_rdata, e.data);
        if (e.chk && e.dv) check("d_rdata", d_rdata, e.data);
        check("i_stall_cnt", 32'(i_stall_cnt), 32'(m_stall));
        last_i_rdata = i_rdata;
        last_d_rdata = d_rdata;
    endtask

    initial begin
        total = 0;
        bad = 0;
        m_streak = 0;
        m_stall = 0;
        dlog = 16'd0;
        last_i_rdata = 32'd0;
        last_d_rdata = 32'd0;
        mem_dout = 32'd0;
        for (int a = 0; a < 256; a++) begin
            ram[a]     = 32'h5A000000 | 32'(a);
            ref_mem[a] = 32'h5A000000 | 32'(a);
        end
        ram[8]     = 32'h20010003;
        ref_mem[8] = 32'h20010003;

        s_nrst = 1'b0; s_i_req = 1'b0; s_d_req = 1'b0;
        s_zero_addr = 8'd0; s_zero_we = 4'd0; s_zero_data = 32'd0;
        s_mem_dout = 32'd0;

        // 1: reset with both requests high, then first grant goes to data
        nrst = 1'b0; i_req = 1'b1; i_addr = 8'd8;
        d_req = 1'b1; d_we = 4'd0; d_addr = 8'd3; d_wdata = 32'd0;
        repeat (3) tick();
        check("rst_cnt", 32'(i_stall_cnt), 32'd0);
        nrst = 1'b1;
        tick();
        check("rst_first_dgnt", 32'(dlog[0]), 32'd1);
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // 2: fetch only
        i_req = 1'b1; i_addr = 8'd8;
        tick();
        i_req = 1'b0;
        check("fetch_word8", last_i_rdata, 32'h20010003);
        tick();

        // 3: full write then read, byte write then read
        d_req = 1'b1; d_we = 4'hF; d_addr = 8'd5; d_wdata = 32'hDEADBEEF;
        tick();
        d_we = 4'h0; d_wdata = 32'd0;
        tick();
        check("wr_rd_full", last_d_rdata, 32'hDEADBEEF);
        d_we = 4'h1; d_wdata = 32'h000000AA;
        tick();
        d_we = 4'h0; d_wdata = 32'd0;
        tick();
        check("wr_rd_byte", last_d_rdata, 32'hDEADBEAA);
        d_req = 1'b0;
        tick();

        // 4: contention for 10 cycles
        stall_before = m_stall;
        i_req = 1'b1; i_addr = 8'd8; d_req = 1'b1; d_addr = 8'd5;
        repeat (10) tick();
        check("contend_order", 32'(dlog[9:0]), 32'(10'b1111011110));
        check("contend_stall", 32'(i_stall_cnt), 32'(stall_before + 8));

        // 5: reset in the cycle after a data grant
        repeat (2) tick();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        repeat (5) tick();
        check("rst_mid_order", 32'(dlog[4:0]), 32'(5'b11110));
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // 6: saturation on the MAX_STREAK=15 instance
        s_nrst = 1'b1; s_i_req = 1'b1; s_d_req = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("sat_16", 32'(s_i_stall_cnt), 32'd15);
        repeat (70000) @(posedge clk);
        #1;
        check("sat_full", 32'(s_i_stall_cnt), 32'h0000FFFF);
        repeat (20) @(posedge clk);
        #1;
        check("sat_hold", 32'(s_i_stall_cnt), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
